// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame checker.
package eth_rx_pkg;

    localparam int HDR_LEN = 14;
    localparam int ERR_W   = 5;

    typedef enum logic {
        S_HDR,
        S_PAY
    } state_t;

    typedef struct packed {
        logic bad_fcs;
        logic runt;
        logic len_err;
        logic pat_err;
        logic dst_err;
    } err_flags_t;

endpackage

// File: rtl/eth_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module eth_sat_counter (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        inc,
    output logic [15:0] count
);

    // Count enabled events, hold at 16'hFFFF, clear synchronously when clr_n is low.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/eth_rx_frame_checker.sv
// Receive frame checker: captures the Ethernet header, checks the payload
// against the generator's incrementing byte pattern and reports per-frame
// status plus saturating frame/error statistics. Never stalls the MAC.
module eth_rx_frame_checker
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'hDA0102030405,
    parameter bit          CHECK_DST   = 1'b1,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1500,
    parameter logic [15:0] MIN_PAYLOAD = 16'd46
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_axis_tdata,
    input  logic             rx_axis_tvalid,
    input  logic             rx_axis_tlast,
    input  logic             rx_axis_tuser,
    output logic [47:0]      dst_mac,
    output logic [47:0]      src_mac,
    output logic [15:0]      payload_len,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [ERR_W-1:0] err_flags,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      err_cnt
);

    localparam logic [15:0] DST_END  = 16'd6;
    localparam logic [15:0] SRC_END  = 16'd12;
    localparam logic [15:0] LEN_HI   = 16'd12;
    localparam logic [15:0] HDR_LAST = 16'(HDR_LEN - 1);

    state_t      state;
    logic [15:0] byte_cnt;
    logic [15:0] pidx;
    logic [47:0] dst_sh;
    logic [47:0] src_sh;
    logic [15:0] len_sh;
    logic        pat_acc;

    logic [47:0] dst_nx;
    logic [47:0] src_nx;
    logic [15:0] len_nx;
    logic        pat_nx;
    logic [16:0] rx_bytes;
    logic [16:0] required;
    err_flags_t  flags;
    logic        frame_end;

    assign frame_end = rx_axis_tvalid & rx_axis_tlast;

    // Shadow registers and error flags as they stand including the current
    // byte, so a tlast beat can be reported without an extra cycle.
    always_comb begin
        dst_nx   = dst_sh;
        src_nx   = src_sh;
        len_nx   = len_sh;
        pat_nx   = pat_acc;
        rx_bytes = {1'b0, pidx} + 17'd1;
        required = (len_sh < MIN_PAYLOAD) ? {1'b0, MIN_PAYLOAD} : {1'b0, len_sh};
        flags    = '0;

        if (state == S_HDR) begin
            if (byte_cnt < DST_END) begin
                dst_nx = {dst_sh[39:0], rx_axis_tdata};
            end else if (byte_cnt < SRC_END) begin
                src_nx = {src_sh[39:0], rx_axis_tdata};
            end else if (byte_cnt == LEN_HI) begin
                len_nx = {rx_axis_tdata, len_sh[7:0]};
            end else if (byte_cnt == HDR_LAST) begin
                len_nx = {len_sh[15:8], rx_axis_tdata};
            end
        end else begin
            if ((pidx < len_sh) && (rx_axis_tdata != pidx[7:0])) begin
                pat_nx = 1'b1;
            end
        end

        flags.bad_fcs = rx_axis_tuser;
        flags.runt    = (state == S_HDR);
        flags.len_err = (state == S_PAY) &&
                        ((len_sh > MAX_PAYLOAD) || (rx_bytes != required));
        flags.pat_err = (state == S_PAY) && pat_nx;
        flags.dst_err = CHECK_DST && (dst_nx != LOCAL_MAC) &&
                        (dst_nx != 48'hFFFFFFFFFFFF);
    end

    // Frame FSM: accumulate header/payload state per valid beat and register
    // the status outputs on the tlast beat while clearing for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_HDR;
            byte_cnt    <= 16'h0000;
            pidx        <= 16'h0000;
            dst_sh      <= 48'h0;
            src_sh      <= 48'h0;
            len_sh      <= 16'h0000;
            pat_acc     <= 1'b0;
            dst_mac     <= 48'h0;
            src_mac     <= 48'h0;
            payload_len <= 16'h0000;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            err_flags   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (rx_axis_tvalid) begin
                if (rx_axis_tlast) begin
                    dst_mac     <= dst_nx;
                    src_mac     <= src_nx;
                    payload_len <= len_nx;
                    err_flags   <= flags;
                    frame_ok    <= ~|flags;
                    frame_done  <= 1'b1;
                    state       <= S_HDR;
                    byte_cnt    <= 16'h0000;
                    pidx        <= 16'h0000;
                    dst_sh      <= 48'h0;
                    src_sh      <= 48'h0;
                    len_sh      <= 16'h0000;
                    pat_acc     <= 1'b0;
                end else begin
                    dst_sh  <= dst_nx;
                    src_sh  <= src_nx;
                    len_sh  <= len_nx;
                    pat_acc <= pat_nx;
                    if (byte_cnt != 16'hFFFF) begin
                        byte_cnt <= byte_cnt + 16'd1;
                    end
                    if (state == S_HDR) begin
                        if (byte_cnt == HDR_LAST) begin
                            state <= S_PAY;
                            pidx  <= 16'h0000;
                        end
                    end else if (pidx != 16'hFFFF) begin
                        pidx <= pidx + 16'd1;
                    end
                end
            end
        end
    end

    eth_sat_counter u_frame_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (frame_end),
        .count (frame_cnt)
    );

    eth_sat_counter u_err_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (frame_end & (|flags)),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Self-checking bench for eth_rx_frame_checker: table of frames driven
// through a scoreboard, plus reset-mid-frame and counter saturation sequences.
module tb_eth_rx_frame_checker;
    import eth_rx_pkg::*;

    localparam logic [47:0] LOCAL = 48'hDA0102030405;
    localparam logic [47:0] SRC   = 48'h001122334455;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] OTHER = 48'h123456789ABC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_axis_tdata;
    logic        rx_axis_tvalid;
    logic        rx_axis_tlast;
    logic        rx_axis_tuser;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] payload_len;
    logic        frame_done;
    logic        frame_ok;
    logic [4:0]  err_flags;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    logic        sc_clr_n;
    logic        sc_inc;
    logic [15:0] sc_count;

    eth_rx_frame_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_axis_tdata  (rx_axis_tdata),
        .rx_axis_tvalid (rx_axis_tvalid),
        .rx_axis_tlast  (rx_axis_tlast),
        .rx_axis_tuser  (rx_axis_tuser),
        .dst_mac        (dst_mac),
        .src_mac        (src_mac),
        .payload_len    (payload_len),
        .frame_done     (frame_done),
        .frame_ok       (frame_ok),
        .err_flags      (err_flags),
        .frame_cnt      (frame_cnt),
        .err_cnt        (err_cnt)
    );

    eth_sat_counter sc (
        .clk   (clk),
        .clr_n (sc_clr_n),
        .inc   (sc_inc),
        .count (sc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] len;
        int          npay;
        int          corrupt;
        int          total;
        logic        tuser;
        int          gaps;
        int          idle_after;
        logic [4:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] len;
        logic [4:0]  flags;
    } exp_t;

    exp_t       sb[$];
    exp_t       last_e;
    logic [7:0] fb[$];
    vec_t       vecs[12];
    int         errors = 0;
    int         checks = 0;
    int         exp_frames = 0;
    int         exp_errs = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_beat(input logic v, input logic [7:0] d, input logic l, input logic u);
        rx_axis_tvalid = v;
        rx_axis_tdata  = d;
        rx_axis_tlast  = l;
        rx_axis_tuser  = u;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_beat(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic build_frame(input vec_t v);
        logic [7:0] b;
        fb.delete();
        for (int i = 5; i >= 0; i--) fb.push_back(v.dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(SRC[i*8 +: 8]);
        fb.push_back(v.len[15:8]);
        fb.push_back(v.len[7:0]);
        for (int p = 0; p < v.npay; p++) begin
            b = (p < int'(v.len)) ? p[7:0] : 8'h00;
            if (p == v.corrupt) b = 8'hFF;
            fb.push_back(b);
        end
        if (v.total >= 0) while (fb.size() > v.total) void'(fb.pop_back());
    endtask

    function automatic exp_t model_frame(input logic [4:0] flags);
        exp_t e;
        e = '0;
        for (int i = 0; i < fb.size() && i < HDR_LEN; i++) begin
            if (i < 6)       e.dst = {e.dst[39:0], fb[i]};
            else if (i < 12) e.src = {e.src[39:0], fb[i]};
            else if (i == 12) e.len[15:8] = fb[i];
            else             e.len[7:0] = fb[i];
        end
        e.flags = flags;
        return e;
    endfunction

    // Drive the current frame bytes, optionally with random idle beats
    // carrying garbage that must be ignored.
    task automatic applyStimulus(input int gaps, input logic tuser_last);
        for (int i = 0; i < fb.size(); i++) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0)
                drive_beat(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
            if (i == fb.size() - 1) drive_beat(1'b1, fb[i], 1'b1, tuser_last);
            else                    drive_beat(1'b1, fb[i], 1'b0, 1'($urandom));
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_dst"}, dst_mac, 0);
        checkOutput({tag, "_src"}, src_mac, 0);
        checkOutput({tag, "_len"}, payload_len, 0);
        checkOutput({tag, "_done"}, frame_done, 0);
        checkOutput({tag, "_ok"}, frame_ok, 0);
        checkOutput({tag, "_flags"}, err_flags, 0);
        checkOutput({tag, "_fcnt"}, frame_cnt, 0);
        checkOutput({tag, "_ecnt"}, err_cnt, 0);
    endtask

    // Scoreboard: every frame_done pulse pops one expected frame report.
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_frame_done", 64'd1, 64'd0);
            end else begin
                last_e = sb.pop_front();
                if (exp_frames < 65535) exp_frames++;
                if (last_e.flags != 0 && exp_errs < 65535) exp_errs++;
                checkOutput("dst_mac", dst_mac, last_e.dst);
                checkOutput("src_mac", src_mac, last_e.src);
                checkOutput("payload_len", payload_len, last_e.len);
                checkOutput("err_flags", err_flags, last_e.flags);
                checkOutput("frame_ok", frame_ok, (last_e.flags == 0));
                checkOutput("frame_cnt", frame_cnt, exp_frames);
                checkOutput("err_cnt", err_cnt, exp_errs);
            end
        end
    end

    initial begin
        // dst, len, npay, corrupt, total, tuser, gaps, idle_after, flags {fcs,runt,len,pat,dst}
        vecs[0]  = '{dst:LOCAL, len:16'd64,   npay:64,   corrupt:-1, total:-1, tuser:0, gaps:0, idle_after:0, flags:5'b00000};
        vecs[1]  = '{dst:LOCAL, len:16'd10,   npay:46,   corrupt:-1, total:-1, tuser:0, gaps:1, idle_after:2, flags:5'b00000};
        vecs[2]  = '{dst:LOCAL, len:16'd10,   npay:45,   corrupt:-1, total:-1, tuser:0, gaps:0, idle_after:1, flags:5'b00100};
        vecs[3]  = '{dst:LOCAL, len:16'd64,   npay:64,   corrupt:20, total:-1, tuser:0, gaps:1, idle_after:0, flags:5'b00010};
        vecs[4]  = '{dst:BCAST, len:16'd64,   npay:64,   corrupt:-1, total:-1, tuser:0, gaps:0, idle_after:0, flags:5'b00000};
        vecs[5]  = '{dst:LOCAL, len:16'd64,   npay:64,   corrupt:-1, total:10, tuser:0, gaps:0, idle_after:0, flags:5'b01000};
        vecs[6]  = '{dst:LOCAL, len:16'd64,   npay:64,   corrupt:-1, total:-1, tuser:1, gaps:0, idle_after:3, flags:5'b10000};
        vecs[7]  = '{dst:LOCAL, len:16'h05DD, npay:64,   corrupt:-1, total:-1, tuser:0, gaps:0, idle_after:0, flags:5'b00100};
        vecs[8]  = '{dst:LOCAL, len:16'd1500, npay:1500, corrupt:-1, total:-1, tuser:0, gaps:0, idle_after:0, flags:5'b00000};
        vecs[9]  = '{dst:OTHER, len:16'd64,   npay:64,   corrupt:-1, total:-1, tuser:0, gaps:1, idle_after:0, flags:5'b00001};
        vecs[10] = '{dst:LOCAL, len:16'd64,   npay:64,   corrupt:-1, total:1,  tuser:0, gaps:0, idle_after:0, flags:5'b01001};
        vecs[11] = '{dst:LOCAL, len:16'd46,   npay:47,   corrupt:-1, total:-1, tuser:0, gaps:0, idle_after:2, flags:5'b00100};

        rst_n = 1'b0;
        sc_clr_n = 1'b0;
        sc_inc = 1'b0;
        rx_axis_tvalid = 1'b0;
        rx_axis_tdata = 8'h00;
        rx_axis_tlast = 1'b0;
        rx_axis_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            build_frame(vecs[k]);
            sb.push_back(model_frame(vecs[k].flags));
            applyStimulus(vecs[k].gaps, vecs[k].tuser);
            idle(vecs[k].idle_after);
        end
        wait_drain("table_drain");
        checkOutput("hold_done", frame_done, 0);
        checkOutput("hold_flags", err_flags, last_e.flags);
        checkOutput("hold_fcnt", frame_cnt, 16'd12);

        // Reset at payload byte 30 of a good frame, then one good frame.
        build_frame(vecs[0]);
        for (int i = 0; i < HDR_LEN + 30; i++) drive_beat(1'b1, fb[i], 1'b0, 1'b0);
        rst_n = 1'b0;
        drive_beat(1'b1, fb[HDR_LEN + 30], 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_frames = 0;
        exp_errs = 0;
        idle(1);
        check_reset_state("midreset");
        sb.push_back(model_frame(5'b00000));
        applyStimulus(0, 1'b0);
        idle(2);
        wait_drain("midreset_drain");
        checkOutput("midreset_fcnt", frame_cnt, 16'd1);
        checkOutput("midreset_ok", frame_ok, 1);

        // Saturating counter: count to the top and stick there.
        @(posedge clk);
        #1;
        sc_clr_n = 1'b1;
        sc_inc = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checkOutput("sat_fffe", sc_count, 16'hFFFE);
        sc_inc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat_hold", sc_count, 16'hFFFE);
        sc_inc = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sat_ffff", sc_count, 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sat_stick", sc_count, 16'hFFFF);
        sc_clr_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("sat_clear", sc_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_checker.md
Name: eth_rx_frame_checker

Overview:
Receive-side counterpart of the pattern generator's transmit byte counter. Consumes the MAC's 8-bit receive AXI-Stream, counts bytes per frame, and extracts the destination MAC, source MAC and length field. It checks payload bytes against the incrementing generator pattern and reports per-frame status plus saturating frame and error statistics. Sits between the tri-mode MAC rx_axis port and the status/register block; no backpressure is applied to the MAC.

Parameters:
LOCAL_MAC, 48'hDA0102030405, destination MAC the checker accepts
CHECK_DST, 1, 1 = flag dst mismatch as error; 0 = ignore dst
MAX_PAYLOAD, 1500, largest legal length-field value
MIN_PAYLOAD, 46, minimum on-wire payload (pad threshold)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
rx_axis_tdata  in  8  received byte
rx_axis_tvalid  in  1  byte valid
rx_axis_tlast  in  1  last byte of frame
rx_axis_tuser  in  1  MAC bad-frame flag, meaningful with tlast
dst_mac  out  48  captured destination MAC of last frame
src_mac  out  48  captured source MAC of last frame
payload_len  out  16  captured length field of last frame
frame_done  out  1  one-cycle pulse: status outputs updated
frame_ok  out  1  last frame passed all checks
err_flags  out  5  {bad_fcs, runt, len_err, pat_err, dst_err}
frame_cnt  out  16  frames completed, saturating
err_cnt  out  16  frames with any error, saturating

Behaviour:
- Reset (rst_n=0 at clk edge): state=S_HDR, byte_cnt=0, all outputs 0, internal error accumulators cleared. Reset mid-frame discards the frame; the next byte after release is treated as byte 0. The MAC delivers bytes until tlast, so the checker must not resynchronise on anything other than tlast.
- Only beats with tvalid=1 advance state. tvalid=0 holds everything.
- byte_cnt is 16-bit, increments per valid beat, saturates at 16'hFFFF, and returns to 0 on a tlast beat.
- S_HDR, bytes 0..13:
  - bytes 0-5 shift into the dst shadow register, MSB first;
  - bytes 6-11 go to the src shadow register;
  - byte 12 is the len high byte and byte 13 the len low byte.
  - At byte 13 go to S_PAY, payload index pidx=0.
  - tlast in S_HDR: runt=1, frame ends, state stays S_HDR.
- S_PAY:
  - Expected byte = pidx[7:0]; the generator sends 0,1,2,… wrapping at 256.
  - Compare only while pidx < len_field. Pad bytes beyond len are not checked.
  - Mismatch sets pat_err (sticky for the frame).
  - pidx increments per beat and saturates.
- Length check at tlast, with rx_bytes = pidx+1 including the tlast byte:
  - len_field > MAX_PAYLOAD -> len_err;
  - else the required count is max(len_field, MIN_PAYLOAD), and rx_bytes != required -> len_err.
- dst_err: CHECK_DST=1, dst shadow != LOCAL_MAC and != 48'hFFFFFFFFFFFF.
- bad_fcs = tuser on the tlast beat.
- Frame end (tlast beat):
  - next cycle: frame_done=1 for exactly one cycle;
  - dst_mac/src_mac/payload_len load from the shadows (partial values if runt);
  - err_flags load and frame_ok = ~|err_flags;
  - frame_cnt++ and err_cnt++ if any flag is set, both saturating at 16'hFFFF.
  - Latency is 1 cycle from the tlast beat. Outputs hold until the next frame_done.
- A new frame may start on the beat immediately after tlast. Its accumulation must not corrupt the outputs being registered.
- A single-byte frame (tlast on byte 0) is a runt, and frame_done still pulses.

Decomposition:
- Package eth_rx_pkg:
  - HDR_LEN=14, ERR_W=5;
  - state enum {S_HDR, S_PAY};
  - packed struct err_flags_t {bad_fcs, runt, len_err, pat_err, dst_err}.
- One sub-module: eth_sat_counter (16-bit, inc enable, synchronous active-low clear, saturating), instantiated twice for frame_cnt and err_cnt.

Test Plan:
- Good frame: dst=LOCAL_MAC, src=0x001122334455, len=0x0040, payload 0x00..0x3F, tuser=0 -> one-cycle frame_done, frame_ok=1, err_flags=0, payload_len=0x0040, frame_cnt=1, err_cnt=0.
- Padded frame: len=10, payload 0..9 then 36 bytes of 0x00 (46 total) -> frame_ok=1. Same with 45 total bytes -> len_err=1, err_cnt=1.
- Pattern error: len=64 frame with byte 20 of the payload set to 0xFF -> pat_err=1, frame_ok=0. A broadcast dst frame with CHECK_DST=1 -> dst_err=0.
- Runt and FCS: tlast on byte 9 -> runt=1. A full good frame with tuser=1 at tlast -> bad_fcs=1 only. Back-to-back frames with zero idle beats -> two distinct frame_done pulses with correct per-frame status.
- Length limits: len=0x05DD -> len_err=1. len=1500 with a correct 1500-byte pattern wrapping past 0xFF -> frame_ok=1.
- Reset mid-frame: assert rst_n=0 at payload byte 30, then send a good frame -> outputs 0 after reset, then exactly one frame_done with frame_ok=1 and frame_cnt=1. Force frame_cnt to 16'hFFFF (or run long) -> frame_cnt holds at 16'hFFFF.
